// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: holds pre-IF slots in order, matches in-order
// icache responses to them, and presents completed head entries to decode.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ps_to_fs_valid    pre-IF slot presented
//   ps_to_fs_bus[38:0] {inst_valid, pc[31:0], ex, exctype[4:0]}
//   fs_allowin        queue has room for one slot this cycle
//   icache_data_ok    one instruction word returned (request order)
//   icache_rdata      returned instruction word
//   flush             empty the queue and discard in-flight responses
//   ds_allowin        decode accepts the head entry this cycle
//   fs_to_ds_valid    head entry complete and presented
//   fs_to_ds_bus[69:0] {pc[31:0], inst[31:0], ex, exctype[4:0]}
module if_fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps_to_fs_valid,
   input  logic [38:0] ps_to_fs_bus,
   output logic        fs_allowin,
   input  logic        icache_data_ok,
   input  logic [31:0] icache_rdata,
   input  logic        flush,
   input  logic        ds_allowin,
   output logic        fs_to_ds_valid,
   output logic [69:0] fs_to_ds_bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [31:0]   r_pc   [DEPTH];
   logic [31:0]   r_inst [DEPTH];
   logic          r_ex   [DEPTH];
   logic [4:0]    r_exc  [DEPTH];
   logic [DEPTH-1:0] r_done;

   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_outst;
   logic [CW-1:0] r_disc;

   logic          w_in_iv;
   logic [31:0]   w_in_pc;
   logic          w_in_ex;
   logic [4:0]    w_in_exc;
   logic          w_acc;
   logic          w_enq;
   logic          w_req;
   logic          w_deq;
   logic          w_rsp_disc;
   logic          w_rsp_fill;
   logic          w_fill_wr;
   logic          w_rsp_live;
   logic          w_nonempty;
   logic [PW-1:0] w_fill_idx;
   logic          w_fill_hit;

   assign w_in_iv  = ps_to_fs_bus[38];
   assign w_in_pc  = ps_to_fs_bus[37:6];
   assign w_in_ex  = ps_to_fs_bus[5];
   assign w_in_exc = ps_to_fs_bus[4:0];

   assign fs_allowin     = (r_count < C_DEPTH);
   assign w_nonempty     = (r_count != '0);
   assign fs_to_ds_valid = w_nonempty & r_done[r_head];
   assign fs_to_ds_bus   = w_nonempty ?
                           {r_pc[r_head], r_inst[r_head],
                            r_ex[r_head], r_exc[r_head]} : 70'h0;

   assign w_acc = ps_to_fs_valid & fs_allowin & ~flush;
   // Non-instruction, non-exception slots are bubbles and vanish here.
   assign w_enq = w_acc & (w_in_iv | w_in_ex);
   assign w_req = w_acc & w_in_iv;
   assign w_deq = fs_to_ds_valid & ds_allowin & ~flush;

   // Responses retire stale (pre-flush) requests before filling entries.
   assign w_rsp_disc = icache_data_ok & (r_disc != '0);
   assign w_rsp_fill = icache_data_ok & (r_disc == '0) & (r_outst != '0);
   assign w_rsp_live = w_rsp_disc | w_rsp_fill;
   assign w_fill_wr  = w_rsp_fill & w_fill_hit & ~flush;

   // Oldest not-yet-done entry; exception entries are born done and
   // are skipped, so a plain counter pointer would not do.
   always_comb begin
      logic [PW-1:0] w_idx;
      w_fill_idx = r_head;
      w_fill_hit = 1'b0;
      w_idx      = r_head;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PW'(i);
         if (!w_fill_hit && (CW'(i) < r_count) && !r_done[w_idx]) begin
            w_fill_idx = w_idx;
            w_fill_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_outst <= '0;
         r_disc  <= '0;
         r_done  <= '0;
      end else if (flush) begin
         r_head  <= r_tail;
         r_count <= '0;
         r_outst <= '0;
         r_done  <= '0;
         // The icache bounds in-flight requests to DEPTH, so this sum
         // stays within the counter range.
         r_disc  <= r_disc + r_outst - CW'(w_rsp_live);
      end else begin
         if (w_enq) begin
            r_done[r_tail] <= ~w_in_iv;
            r_tail         <= r_tail + 1'b1;
         end
         if (w_fill_wr) begin
            r_done[w_fill_idx] <= 1'b1;
         end
         if (w_deq) begin
            r_head <= r_head + 1'b1;
         end
         r_count <= r_count + CW'(w_enq) - CW'(w_deq);
         r_outst <= r_outst + CW'(w_req) - CW'(w_rsp_fill);
         r_disc  <= r_disc - CW'(w_rsp_disc);
      end
   end

   // Payload storage needs no reset: it is masked by count and done.
   always_ff @(posedge clk) begin
      if (!reset && w_enq) begin
         r_pc[r_tail]   <= w_in_pc;
         r_inst[r_tail] <= 32'h0;
         r_ex[r_tail]   <= w_in_ex;
         r_exc[r_tail]  <= w_in_exc;
      end
      if (!reset && w_fill_wr) begin
         r_inst[w_fill_idx] <= icache_rdata;
      end
   end

endmodule
